// File: rtl/des_block_seq.sv
// Block sequencer feeding a round-iterated 64-bit cipher core from/to RAM ports.
// Optional CBC chaining when DES_SEQ_CBC_EN is defined (adds iv port).
module des_block_seq #(
  parameter int DW = 32,
  parameter int ADDR_W = 9,
  parameter int ROUNDS = 16,
  parameter int RD_LAT = 1,
  localparam int WPB = 64 / DW,
  localparam int ROUND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1,
  localparam int BLK_W = ADDR_W - $clog2(WPB)
) (
  input  logic               clk1,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               decrypt_in,
  input  logic [BLK_W-1:0]   num_blocks,
`ifdef DES_SEQ_CBC_EN
  input  logic [63:0]        iv,
`endif
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DW-1:0]      rd_data,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic               wr_en,
  output logic [63:0]        core_in,
  output logic [ROUND_W-1:0] core_round,
  output logic               core_decrypt,
  input  logic [63:0]        core_out,
  output logic               busy,
  output logic               done,
  output logic [BLK_W:0]     blocks_done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ROUND, STORE, DONE
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);
  localparam logic [2:0] NWPB = 3'(WPB);
  localparam logic [2:0] W_LAST = 3'(WPB - 1);
  localparam logic [2:0] L_LAST = 3'(WPB + RD_LAT - 1);
  localparam logic [ROUND_W-1:0] R_LAST = ROUND_W'(ROUNDS - 1);

  state_t           state;
  logic [2:0]       ph;
  logic [2:0]       widx;
  logic [2:0]       nidx;
  logic [BLK_W:0]   target;
  logic [BLK_W:0]   bd_next;
  logic [63:0]      res;
  logic [63:0]      rnext;
`ifdef DES_SEQ_CBC_EN
  logic [63:0]      chain;
`endif

  assign widx = ph - LAT;
  assign nidx = ph + 3'd1;
  assign bd_next = blocks_done + (BLK_W+1)'(1);

  always_comb begin
    rnext = core_out;
`ifdef DES_SEQ_CBC_EN
    if (core_decrypt) rnext = core_out ^ chain;
`endif
  end

  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ph           <= '0;
      target       <= '0;
      res          <= '0;
      rd_addr      <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_en        <= 1'b0;
      core_in      <= '0;
      core_round   <= '0;
      core_decrypt <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      blocks_done  <= '0;
`ifdef DES_SEQ_CBC_EN
      chain        <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            target       <= (num_blocks == '0) ?
                            {1'b1, {BLK_W{1'b0}}} :
                            {1'b0, num_blocks};
            core_decrypt <= decrypt_in;
            blocks_done  <= '0;
            rd_addr      <= '0;
            wr_addr      <= '0;
            ph           <= '0;
            busy         <= 1'b1;
            state        <= LOAD;
`ifdef DES_SEQ_CBC_EN
            chain        <= iv;
`endif
          end
        end
        LOAD: begin
          if (ph < NWPB) rd_addr <= rd_addr + ADDR_W'(1);
          if (ph >= LAT) begin
            for (int k = 0; k < WPB; k++) begin
              if (widx == 3'(k)) begin
`ifdef DES_SEQ_CBC_EN
                core_in[k*DW +: DW] <= core_decrypt ? rd_data :
                                       rd_data ^ chain[k*DW +: DW];
`else
                core_in[k*DW +: DW] <= rd_data;
`endif
              end
            end
          end
          if (ph == L_LAST) begin
            ph         <= '0;
            core_round <= '0;
            state      <= ROUND;
          end else begin
            ph <= nidx;
          end
        end
        ROUND: begin
          if (core_round == R_LAST) begin
            res        <= rnext;
            wr_data    <= rnext[DW-1:0];
            wr_en      <= 1'b1;
            core_round <= '0;
            ph         <= '0;
            state      <= STORE;
`ifdef DES_SEQ_CBC_EN
            // decrypt chains on the ciphertext as it was read
            chain      <= core_decrypt ? core_in : core_out;
`endif
          end else begin
            core_round <= core_round + ROUND_W'(1);
          end
        end
        STORE: begin
          wr_addr <= wr_addr + ADDR_W'(1);
          if (ph == W_LAST) begin
            wr_en       <= 1'b0;
            blocks_done <= bd_next;
            ph          <= '0;
            if (bd_next == target) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= LOAD;
            end
          end else begin
            ph <= nidx;
            for (int k = 0; k < WPB; k++) begin
              if (nidx == 3'(k)) wr_data <= res[k*DW +: DW];
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      // a write already on the bus in this cycle still lands
      if (abort && busy) begin
        state      <= IDLE;
        busy       <= 1'b0;
        wr_en      <= 1'b0;
        done       <= 1'b0;
        ph         <= '0;
        core_round <= '0;
      end
    end
  end

endmodule

// File: tb/tb_des_block_seq.sv
// Directed bench for des_block_seq with RAM models and a stand-in cipher core.
// Core is exact for the 0x0123456789ABCDEF DES vector, invertible mock otherwise.
module tb_des_block_seq;

  localparam int DW = 32;
  localparam int ADDR_W = 9;
  localparam int BLK_W = 8;

  logic              clk1 = 1'b0;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic              decrypt_in;
  logic [BLK_W-1:0]  num_blocks;
  logic [ADDR_W-1:0] rd_addr;
  logic [DW-1:0]     rd_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [DW-1:0]     wr_data;
  logic              wr_en;
  logic [63:0]       core_in;
  logic [3:0]        core_round;
  logic              core_decrypt;
  logic [63:0]       core_out;
  logic              busy;
  logic              done;
  logic [BLK_W:0]    blocks_done;
`ifdef DES_SEQ_CBC_EN
  logic [63:0]       iv = '0;
`endif

  logic [DW-1:0] mem_in [512];
  logic [DW-1:0] mem_out [512];

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk1 = ~clk1;

  des_block_seq dut (
    .clk1(clk1), .reset_n(reset_n), .start(start), .abort(abort),
    .decrypt_in(decrypt_in), .num_blocks(num_blocks),
`ifdef DES_SEQ_CBC_EN
    .iv(iv),
`endif
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_en(wr_en), .core_in(core_in),
    .core_round(core_round), .core_decrypt(core_decrypt),
    .core_out(core_out), .busy(busy), .done(done),
    .blocks_done(blocks_done)
  );

  function automatic logic [63:0] mock(input logic [63:0] x, input logic d);
    logic [63:0] y;
    if (!d) begin
      if (x == 64'h0123456789ABCDEF) return 64'h85E813540F0AB405;
      return {x[55:0], x[63:56]} ^ 64'h5A5A0F0F3C3CC3C3;
    end
    if (x == 64'h85E813540F0AB405) return 64'h0123456789ABCDEF;
    y = x ^ 64'h5A5A0F0F3C3CC3C3;
    return {y[7:0], y[63:8]};
  endfunction

  // result is only meaningful in the last round
  assign core_out = (core_round == 4'd15) ? mock(core_in, core_decrypt)
                                          : ~mock(core_in, core_decrypt);

  always @(posedge clk1) rd_data <= mem_in[rd_addr];
  always @(posedge clk1) if (wr_en) mem_out[wr_addr] <= wr_data;

  task automatic tick();
    @(posedge clk1);
    #1;
    cyc++;
  endtask

  task automatic kick(input logic [BLK_W-1:0] nb, input logic dec);
    @(posedge clk1);
    #1;
    num_blocks = nb;
    decrypt_in = dec;
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_out();
    for (int i = 0; i < 512; i++) mem_out[i] = 32'hDEADBEEF;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    decrypt_in = 1'b0;
    num_blocks = '0;
    repeat (3) @(posedge clk1);
    #1;
    checks++;
    if ({rd_addr, wr_addr, wr_data} !== '0) begin
      errs++;
      $display("FAIL reset_addr got=%h exp=0", {rd_addr, wr_addr, wr_data});
    end
    checks++;
    if ({wr_en, busy, done, core_decrypt} !== 4'b0) begin
      errs++;
      $display("FAIL reset_flags got=%b exp=0000",
               {wr_en, busy, done, core_decrypt});
    end
    checks++;
    if ({core_in, core_round, blocks_done} !== '0) begin
      errs++;
      $display("FAIL reset_core got=%h exp=0",
               {core_in, core_round, blocks_done});
    end
    @(negedge clk1);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int dc = -1;
    int berr = 0;
    clear_out();
    mem_in[0] = 32'h89ABCDEF;
    mem_in[1] = 32'h01234567;
    kick(8'd1, 1'b0);
    while (cyc < 40) begin
      if (done === 1'b1 && dc < 0) dc = cyc;
      if (busy !== (cyc <= 21)) berr++;
      tick();
    end
    checks++;
    if (dc != 22) begin
      errs++;
      $display("FAIL single_done_cycle got=%0d exp=22", dc);
    end
    checks++;
    if (berr != 0) begin
      errs++;
      $display("FAIL single_busy_window got=%0d bad cycles exp=0", berr);
    end
    checks++;
    if (mem_out[0] !== 32'h0F0AB405 || mem_out[1] !== 32'h85E81354) begin
      errs++;
      $display("FAIL single_data got=%h_%h exp=85e81354_0f0ab405",
               mem_out[1], mem_out[0]);
    end
    checks++;
    if (blocks_done !== 9'd1 || mem_out[2] !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL single_count got=%0d/%h exp=1/deadbeef",
               blocks_done, mem_out[2]);
    end
  endtask

  task automatic test_decrypt();
    int dc = -1;
    logic dec_seen = 1'b0;
    clear_out();
    mem_in[0] = 32'h0F0AB405;
    mem_in[1] = 32'h85E81354;
    kick(8'd1, 1'b1);
    while (cyc < 40) begin
      if (done === 1'b1 && dc < 0) dc = cyc;
      if (cyc == 5) dec_seen = core_decrypt;
      if (cyc == 6) decrypt_in = 1'b0;
      tick();
    end
    checks++;
    if (dec_seen !== 1'b1 || dc != 22) begin
      errs++;
      $display("FAIL decrypt_mode got=%b/%0d exp=1/22", dec_seen, dc);
    end
    checks++;
    if (mem_out[0] !== 32'h89ABCDEF || mem_out[1] !== 32'h01234567) begin
      errs++;
      $display("FAIL decrypt_data got=%h_%h exp=01234567_89abcdef",
               mem_out[1], mem_out[0]);
    end
  endtask

  task automatic test_multi();
    int dc = -1;
    int bad = 0;
    logic [63:0] x;
    logic [63:0] y;
    clear_out();
    mem_in[0] = 32'h89ABCDEF;
    mem_in[1] = 32'h01234567;
    mem_in[2] = 32'h11112222;
    mem_in[3] = 32'h33334444;
    mem_in[4] = 32'hCAFEF00D;
    mem_in[5] = 32'h0BADBEEF;
    mem_in[6] = 32'h00000000;
    mem_in[7] = 32'hFFFFFFFF;
    kick(8'd4, 1'b0);
    while (cyc < 100) begin
      if (done === 1'b1 && dc < 0) dc = cyc;
      if (cyc == 30) num_blocks = 8'd1;
      tick();
    end
    for (int b = 0; b < 4; b++) begin
      x = {mem_in[2*b+1], mem_in[2*b]};
      y = mock(x, 1'b0);
      if (mem_out[2*b] !== y[31:0] || mem_out[2*b+1] !== y[63:32]) bad++;
    end
    checks++;
    if (dc != 85) begin
      errs++;
      $display("FAIL multi_done_cycle got=%0d exp=85", dc);
    end
    checks++;
    if (bad != 0 || mem_out[8] !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL multi_data got=%0d bad blocks, w8=%h exp=0/deadbeef",
               bad, mem_out[8]);
    end
    checks++;
    if (blocks_done !== 9'd4 || wr_addr !== 9'd8 || rd_addr !== 9'd8) begin
      errs++;
      $display("FAIL multi_count got=%0d/%0d/%0d exp=4/8/8",
               blocks_done, wr_addr, rd_addr);
    end
  endtask

  task automatic test_full();
    int dc = -1;
    int bad = 0;
    logic [63:0] x;
    logic [63:0] y;
    clear_out();
    for (int i = 0; i < 512; i++) mem_in[i] = (i * 32'h01010101) ^ 32'hC0DE0000;
    kick(8'd0, 1'b0);
    while (cyc < 5500 && dc < 0) begin
      if (done === 1'b1) dc = cyc;
      else tick();
    end
    for (int b = 0; b < 256; b++) begin
      x = {mem_in[2*b+1], mem_in[2*b]};
      y = mock(x, 1'b0);
      if (mem_out[2*b] !== y[31:0] || mem_out[2*b+1] !== y[63:32]) bad++;
    end
    checks++;
    if (dc != 5377) begin
      errs++;
      $display("FAIL full_done_cycle got=%0d exp=5377", dc);
    end
    checks++;
    if (rd_addr !== 9'd0 || wr_addr !== 9'd0 || blocks_done !== 9'd256) begin
      errs++;
      $display("FAIL full_wrap got=%0d/%0d/%0d exp=0/0/256",
               rd_addr, wr_addr, blocks_done);
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL full_data got=%0d bad blocks exp=0", bad);
    end
    repeat (3) tick();
  endtask

  task automatic test_abort();
    int dseen = 0;
    logic b31;
    logic [BLK_W:0] bd31;
    logic [63:0] y;
    clear_out();
    mem_in[0] = 32'h89ABCDEF;
    mem_in[1] = 32'h01234567;
    kick(8'd4, 1'b0);
    while (cyc < 100) begin
      abort = (cyc == 30);
      if (done === 1'b1) dseen++;
      if (cyc == 31) begin
        b31 = busy;
        bd31 = blocks_done;
      end
      tick();
    end
    abort = 1'b0;
    checks++;
    if (b31 !== 1'b0 || bd31 !== 9'd1 || dseen != 0) begin
      errs++;
      $display("FAIL abort_state got=busy%b/bd%0d/done%0d exp=0/1/0",
               b31, bd31, dseen);
    end
    checks++;
    if (mem_out[1] !== 32'h85E81354 || mem_out[2] !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL abort_writes got=%h/%h exp=85e81354/deadbeef",
               mem_out[1], mem_out[2]);
    end
    clear_out();
    mem_in[0] = 32'h55AA00FF;
    mem_in[1] = 32'h12345678;
    y = mock({mem_in[1], mem_in[0]}, 1'b0);
    dseen = -1;
    kick(8'd1, 1'b0);
    while (cyc < 40) begin
      if (done === 1'b1 && dseen < 0) dseen = cyc;
      tick();
    end
    checks++;
    if (dseen != 22 || mem_out[0] !== y[31:0] || mem_out[1] !== y[63:32]) begin
      errs++;
      $display("FAIL abort_rerun got=%0d/%h_%h exp=22/%h",
               dseen, mem_out[1], mem_out[0], y);
    end
  endtask

  task automatic test_restart();
    int dseen = 0;
    int dc = -1;
    logic [ADDR_W-1:0] ra30;
    logic [BLK_W:0] bd30;
    clear_out();
    mem_in[0] = 32'h89ABCDEF;
    mem_in[1] = 32'h01234567;
    kick(8'd4, 1'b0);
    while (cyc < 40) begin
      start = (cyc == 10);
      if (done === 1'b1) dseen++;
      if (cyc == 30) begin
        ra30 = rd_addr;
        bd30 = blocks_done;
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (ra30 !== 9'd4 || bd30 !== 9'd1 || dseen != 0) begin
      errs++;
      $display("FAIL restart_ignored got=ra%0d/bd%0d/done%0d exp=4/1/0",
               ra30, bd30, dseen);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rd_addr, wr_addr, wr_data, wr_en, busy, done, core_decrypt,
         core_in, core_round, blocks_done} !== '0) begin
      errs++;
      $display("FAIL restart_reset got=busy%b bd%0d ra%0d ci%h exp=0",
               busy, blocks_done, rd_addr, core_in);
    end
    repeat (2) tick();
    dseen = 0;
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1) dseen++;
      tick();
    end
    @(negedge clk1);
    reset_n = 1'b1;
    clear_out();
    kick(8'd1, 1'b0);
    while (cyc < 40) begin
      if (done === 1'b1 && dc < 0) dc = cyc;
      tick();
    end
    checks++;
    if (dc != 22 || dseen != 0 || mem_out[0] !== 32'h0F0AB405) begin
      errs++;
      $display("FAIL restart_clean got=%0d/%0d/%h exp=22/0/0f0ab405",
               dc, dseen, mem_out[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_decrypt();
    test_multi();
    test_full();
    test_abort();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
